// File: rtl/jump_ctrl.sv
// ---------------------------------------------------------------------------
// jump_ctrl
//   Sequencing and branch-resolution stage that sits directly in front of the
//   program counter. It owns the run state machine (IDLE / RUN / DONE /
//   RESTART) and resolves the decoder's branch ops. Resolution uses a
//   registered zero flag and a writable offset LUT. The PC controls for the
//   current instruction are produced in the same cycle.
//
// Parameters
//   PCW : PC / offset width
//   LW  : LUT index width (2**LW entries of PCW bits)
//   CW  : width of the saturating cycle / jump counters
//
// Ports
//   CLK         : clock, all state changes on posedge
//   Reset       : synchronous active-high reset
//   Start       : begin / restart program execution
//   Branch_Op   : 00 none, 01 always, 10 if zero, 11 if not zero
//   Dir         : 0 forward jump, 1 backward jump
//   Lut_Idx     : offset LUT read index for the current instruction
//   Halt_Op     : current instruction is a halt
//   Flag_Wr     : load Zero_In into the zero flag
//   Zero_In     : ALU zero result
//   Lut_We      : LUT write enable
//   Lut_Waddr   : LUT write index
//   Lut_Wdata   : LUT write data (unsigned magnitude)
//   PC_Reset    : PC reset request
//   PC_Halt     : PC freeze request
//   For_Jump    : PC forward jump
//   Back_Jump   : PC backward jump
//   Offset      : jump magnitude for the PC
//   Busy        : state is RUN
//   Done        : state is DONE
//   Cycle_Count : RUN cycles since the last RUN entry (saturating)
//   Jump_Count  : taken jumps since the last RUN entry (saturating)
// ---------------------------------------------------------------------------
module jump_ctrl #(
  parameter int PCW = 16,
  parameter int LW  = 4,
  parameter int CW  = 16
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Start,
  input  logic [1:0]     Branch_Op,
  input  logic           Dir,
  input  logic [LW-1:0]  Lut_Idx,
  input  logic           Halt_Op,
  input  logic           Flag_Wr,
  input  logic           Zero_In,
  input  logic           Lut_We,
  input  logic [LW-1:0]  Lut_Waddr,
  input  logic [PCW-1:0] Lut_Wdata,
  output logic           PC_Reset,
  output logic           PC_Halt,
  output logic           For_Jump,
  output logic           Back_Jump,
  output logic [PCW-1:0] Offset,
  output logic           Busy,
  output logic           Done,
  output logic [CW-1:0]  Cycle_Count,
  output logic [CW-1:0]  Jump_Count
);

  localparam int DEPTH = 2 ** LW;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_DONE    = 2'b10;
  localparam logic [1:0] S_RESTART = 2'b11;

  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [PCW-1:0] OFS_ZERO = {PCW{1'b0}};

  logic [1:0]     state_q, state_d;
  logic           zero_q, zero_d;
  logic [CW-1:0]  cycle_q, cycle_d;
  logic [CW-1:0]  jump_q, jump_d;
  logic [PCW-1:0] lut_q [DEPTH];
  logic [PCW-1:0] lut_d [DEPTH];

  logic run_act_s;
  logic cond_s;
  logic taken_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Branch resolution for the instruction presented this cycle.
  always_comb begin
    // Reset in flight suppresses any jump or halt from the still-RUN state.
    run_act_s = (state_q == S_RUN) && !Reset;
    case (Branch_Op)
      2'b00:   cond_s = 1'b0;
      2'b01:   cond_s = 1'b1;
      2'b10:   cond_s = zero_q;
      2'b11:   cond_s = !zero_q;
      default: cond_s = 1'b0;
    endcase
    taken_s   = run_act_s && !Halt_Op && cond_s;
    For_Jump  = taken_s && !Dir;
    Back_Jump = taken_s && Dir;
    Offset    = taken_s ? lut_q[Lut_Idx] : OFS_ZERO;
  end

  // State-decoded PC controls and status.
  always_comb begin
    PC_Reset    = (state_q == S_IDLE) || (state_q == S_RESTART);
    PC_Halt     = (state_q == S_DONE) || (run_act_s && Halt_Op);
    Busy        = (state_q == S_RUN);
    Done        = (state_q == S_DONE);
    Cycle_Count = cycle_q;
    Jump_Count  = jump_q;
  end

  // Next state and counters; entering RUN always starts counting from zero.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    jump_d  = jump_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          cycle_d = CNT_ZERO;
          jump_d  = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cycle_d = sat_inc(cycle_q);
        jump_d  = taken_s ? sat_inc(jump_q) : jump_q;
        state_d = Halt_Op ? S_DONE : S_RUN;
      end
      S_DONE: begin
        state_d = Start ? S_RESTART : S_DONE;
      end
      S_RESTART: begin
        state_d = S_RUN;
        cycle_d = CNT_ZERO;
        jump_d  = CNT_ZERO;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Zero flag and LUT writes; readers this cycle still see the old contents.
  always_comb begin
    zero_d = Flag_Wr ? Zero_In : zero_q;
    for (int i = 0; i < DEPTH; i++) begin
      lut_d[i] = (Lut_We && (Lut_Waddr == LW'(i))) ? Lut_Wdata : lut_q[i];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      zero_q  <= 1'b0;
      cycle_q <= CNT_ZERO;
      jump_q  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= OFS_ZERO;
      end
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      cycle_q <= cycle_d;
      jump_q  <= jump_d;
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= lut_d[i];
      end
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jump_ctrl
//   Directed bench for jump_ctrl. Two instances share the stimulus: the
//   default one (CW=16) and a CW=4 one used for counter saturation.
//   Expected outputs come from a small behavioural model, are queued when
//   the stimulus is applied, and are popped and compared at the negedge.
// ---------------------------------------------------------------------------
module tb_jump_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset, Start, Dir, Halt_Op, Flag_Wr, Zero_In, Lut_We;
  logic [1:0]  Branch_Op;
  logic [3:0]  Lut_Idx, Lut_Waddr;
  logic [15:0] Lut_Wdata;

  logic        PC_Reset, PC_Halt, For_Jump, Back_Jump, Busy, Done;
  logic [15:0] Offset, Cycle_Count, Jump_Count;

  logic        pr4, ph4, fj4, bj4, busy4, done4;
  logic [15:0] ofs4;
  logic [3:0]  cc4, jc4;

  jump_ctrl u_dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Branch_Op(Branch_Op), .Dir(Dir),
    .Lut_Idx(Lut_Idx), .Halt_Op(Halt_Op), .Flag_Wr(Flag_Wr), .Zero_In(Zero_In),
    .Lut_We(Lut_We), .Lut_Waddr(Lut_Waddr), .Lut_Wdata(Lut_Wdata),
    .PC_Reset(PC_Reset), .PC_Halt(PC_Halt), .For_Jump(For_Jump), .Back_Jump(Back_Jump),
    .Offset(Offset), .Busy(Busy), .Done(Done), .Cycle_Count(Cycle_Count),
    .Jump_Count(Jump_Count)
  );

  jump_ctrl #(.PCW(16), .LW(4), .CW(4)) u_dut4 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Branch_Op(Branch_Op), .Dir(Dir),
    .Lut_Idx(Lut_Idx), .Halt_Op(Halt_Op), .Flag_Wr(Flag_Wr), .Zero_In(Zero_In),
    .Lut_We(Lut_We), .Lut_Waddr(Lut_Waddr), .Lut_Wdata(Lut_Wdata),
    .PC_Reset(pr4), .PC_Halt(ph4), .For_Jump(fj4), .Back_Jump(bj4),
    .Offset(ofs4), .Busy(busy4), .Done(done4), .Cycle_Count(cc4),
    .Jump_Count(jc4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [61:0] v;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state (0 IDLE, 1 RUN, 2 DONE, 3 RESTART).
  int          m_st = 0;
  bit          m_z = 1'b0;
  logic [15:0] m_lut [16];
  int          m_cyc = 0, m_jmp = 0, m_cyc4 = 0, m_jmp4 = 0;
  int          held;

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic logic [61:0] obs();
    return {PC_Reset, PC_Halt, For_Jump, Back_Jump, Offset, Busy, Done,
            Cycle_Count, Jump_Count, cc4, jc4};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clock: predict outputs for the current inputs, advance the model,
  // then compare at the negedge and return just after the next posedge.
  task automatic cycle(input string tag);
    exp_t        e;
    exp_t        got;
    bit          run, cond, taken;
    logic [15:0] off;
    logic [61:0] o;
    run   = (m_st == 1) && !Reset;
    cond  = (Branch_Op == 2'b01) || (Branch_Op == 2'b10 && m_z) ||
            (Branch_Op == 2'b11 && !m_z);
    taken = run && !Halt_Op && cond;
    off   = taken ? m_lut[Lut_Idx] : 16'd0;
    e.tag = tag;
    e.v   = {(m_st == 0 || m_st == 3), ((m_st == 2) || (run && Halt_Op)),
             (taken && !Dir), (taken && Dir), off, (m_st == 1), (m_st == 2),
             16'(m_cyc), 16'(m_jmp), 4'(m_cyc4), 4'(m_jmp4)};
    sb.push_back(e);
    if (Reset) begin
      m_st = 0; m_z = 1'b0; m_cyc = 0; m_jmp = 0; m_cyc4 = 0; m_jmp4 = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 16'd0;
    end else begin
      if (Flag_Wr) m_z = Zero_In;
      if (Lut_We) m_lut[Lut_Waddr] = Lut_Wdata;
      case (m_st)
        0: if (Start) begin m_st = 1; m_cyc = 0; m_jmp = 0; m_cyc4 = 0; m_jmp4 = 0; end
        1: begin
          m_cyc  = sat(m_cyc, 65535);
          m_cyc4 = sat(m_cyc4, 15);
          if (taken) begin
            m_jmp  = sat(m_jmp, 65535);
            m_jmp4 = sat(m_jmp4, 15);
          end
          if (Halt_Op) m_st = 2;
        end
        2: if (Start) m_st = 3;
        3: begin m_st = 1; m_cyc = 0; m_jmp = 0; m_cyc4 = 0; m_jmp4 = 0; end
        default: m_st = 0;
      endcase
    end
    @(negedge CLK);
    got = sb.pop_front();
    o   = obs();
    n_tests++;
    assert (o === got.v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", got.tag, o, got.v);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_lut[i] = 16'd0;
    Reset = 1'b1; Start = 1'b0; Branch_Op = 2'b00; Dir = 1'b0; Lut_Idx = 4'd0;
    Halt_Op = 1'b0; Flag_Wr = 1'b0; Zero_In = 1'b0; Lut_We = 1'b0;
    Lut_Waddr = 4'd0; Lut_Wdata = 16'd0;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;

    // 1: reset state, start, counting
    cycle("reset_idle");
    Start = 1'b1; cycle("t1_start");
    Start = 1'b0; cycle("t1_run0");
    cycle("t1_run1");
    cycle("t1_run2");
    chk("t1_cyc", 32'(Cycle_Count), 32'd3);

    // 2: unconditional forward jump through the LUT
    Lut_We = 1'b1; Lut_Waddr = 4'd3; Lut_Wdata = 16'd5; cycle("t2_lutwr");
    Lut_We = 1'b0; Branch_Op = 2'b01; Dir = 1'b0; Lut_Idx = 4'd3; cycle("t2_fwd");
    Branch_Op = 2'b00;
    chk("t2_jcnt", 32'(Jump_Count), 32'd1);
    Branch_Op = 2'b11; cycle("t2_nz_fwd");

    // 3: zero flag timing and backward jump
    Branch_Op = 2'b00; Lut_We = 1'b1; Lut_Waddr = 4'd2; Lut_Wdata = 16'd4;
    Flag_Wr = 1'b1; Zero_In = 1'b1; cycle("t3_flag");
    Lut_We = 1'b0; Flag_Wr = 1'b0; Branch_Op = 2'b10; Dir = 1'b1; Lut_Idx = 4'd2;
    cycle("t3_back");
    Branch_Op = 2'b11; cycle("t3_nz_nojump");
    Branch_Op = 2'b00; Flag_Wr = 1'b1; Zero_In = 1'b0; cycle("t3_clrz");
    Zero_In = 1'b1; Branch_Op = 2'b10; cycle("t3_same_cycle");
    Flag_Wr = 1'b0; cycle("t3_newz");
    chk("t3_jcnt", 32'(Jump_Count), 32'd4);

    // 4: halt, done, restart; Start ignored in RUN
    Branch_Op = 2'b00; Start = 1'b1; cycle("t4_start_ignored");
    Start = 1'b0; Halt_Op = 1'b1; Branch_Op = 2'b01; Dir = 1'b0; Lut_Idx = 4'd3;
    cycle("t4_halt");
    Halt_Op = 1'b0; Branch_Op = 2'b00;
    held = m_cyc;
    cycle("t4_done");
    cycle("t4_done_hold");
    chk("t4_freeze", 32'(Cycle_Count), 32'(held));
    Start = 1'b1; cycle("t4_start");
    Start = 1'b0; cycle("t4_restart");
    chk("t4_cyc0", 32'(Cycle_Count), 32'd0);
    chk("t4_jmp0", 32'(Jump_Count), 32'd0);
    cycle("t4_run_clr");

    // 5: reset mid-RUN with an always-branch pending
    Branch_Op = 2'b01; Lut_Idx = 4'd3; Reset = 1'b1; cycle("t5_reset_run");
    Reset = 1'b0; Branch_Op = 2'b00; cycle("t5_idle");
    Start = 1'b1; cycle("t5_start");
    Start = 1'b0; Branch_Op = 2'b01; Lut_Idx = 4'd3; cycle("t5_lut_cleared");
    Branch_Op = 2'b00;

    // 6: saturation on the narrow instance, write-then-read LUT ordering
    for (int k = 0; k < 20; k++) cycle("t6_run");
    chk("t6_sat4", 32'(cc4), 32'd15);
    chk("t6_cyc16", 32'(Cycle_Count), 32'd21);
    Lut_We = 1'b1; Lut_Waddr = 4'd1; Lut_Wdata = 16'd9;
    Branch_Op = 2'b01; Dir = 1'b0; Lut_Idx = 4'd1; cycle("t6_wr_read_old");
    Lut_We = 1'b0; cycle("t6_read_new");
    Branch_Op = 2'b00; Halt_Op = 1'b1; cycle("t6_halt");
    Halt_Op = 1'b0; cycle("t6_done");
    chk("t6_sat4_hold", 32'(cc4), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
